exe_div_unit: RTL

//  Multi-cycle 32-bit integer divider in the EXE stage, fed from the ID/EXE pipeline register outputs.

---
 rtl/exe_div_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/exe_div_unit.sv
// EXE-stage multi-cycle divider for MIPS DIV/DIVU: radix-2 restoring, one quotient bit per cycle.
// Stalls the pipeline while iterating and returns HI (remainder) / LO (quotient) with a done pulse.
module exe_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              div_start,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] div_src1,
    input  logic [DATA_W-1:0] div_src2,
    input  logic              div_cancel,
    output logic              div_stall_req,
    output logic              div_done,
    output logic [DATA_W-1:0] div_hi,
    output logic [DATA_W-1:0] div_lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] ZERO_W   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONES_W   = {DATA_W{1'b1}};

    // Two's complement magnitude; INT_MIN wraps onto itself, read as unsigned.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic en);
        abs_val = (en && v[DATA_W-1]) ? (ZERO_W - v) : v;
    endfunction

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic en);
        cond_neg = en ? (ZERO_W - v) : v;
    endfunction

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   rem_r, quo_r, dvs_r, hi_r, lo_r;
    logic                neg_q_r, neg_r_r;
    logic                accept_s, last_s;
    logic [DATA_W:0]     rem_sh_s, trial_s;
    logic                ge_s;
    logic [DATA_W-1:0]   rem_nx_s, quo_nx_s;

    assign accept_s = (state_r == ST_IDLE) && div_start && !div_cancel;
    assign last_s   = (cnt_r == CNT_LAST);

    // One restoring step: shift {rem,quo} left and subtract the divisor when it fits.
    always_comb begin
        rem_sh_s = {rem_r, quo_r[DATA_W-1]};
        trial_s  = rem_sh_s - {1'b0, dvs_r};
        ge_s     = (rem_sh_s >= {1'b0, dvs_r});
        if (ge_s) begin
            rem_nx_s = trial_s[DATA_W-1:0];
        end else begin
            rem_nx_s = rem_sh_s[DATA_W-1:0];
        end
        quo_nx_s = {quo_r[DATA_W-2:0], ge_s};
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = (div_src2 == ZERO_W) ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (div_cancel) begin
                    state_s = ST_IDLE;
                end else if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, iteration, and sign fix-up of the registered results.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            rem_r   <= ZERO_W;
            quo_r   <= ZERO_W;
            dvs_r   <= ZERO_W;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            hi_r    <= ZERO_W;
            lo_r    <= ZERO_W;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        rem_r   <= ZERO_W;
                        quo_r   <= abs_val(div_src1, div_signed);
                        dvs_r   <= abs_val(div_src2, div_signed);
                        neg_q_r <= div_signed && (div_src1[DATA_W-1] ^ div_src2[DATA_W-1]);
                        neg_r_r <= div_signed && div_src1[DATA_W-1];
                        // Divide by zero skips iteration; HI keeps the raw dividend.
                        if (div_src2 == ZERO_W) begin
                            lo_r <= ONES_W;
                            hi_r <= div_src1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!div_cancel) begin
                        rem_r <= rem_nx_s;
                        quo_r <= quo_nx_s;
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (last_s) begin
                            lo_r <= cond_neg(quo_nx_s, neg_q_r);
                            hi_r <= cond_neg(rem_nx_s, neg_r_r);
                        end
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign div_stall_req = accept_s || (state_r == ST_RUN);
    assign div_done      = (state_r == ST_DONE) && !div_cancel;
    assign div_hi        = hi_r;
    assign div_lo        = lo_r;

endmodule
